mem_port_arbiter: RTL

- Shares one single-port, fixed-latency unified memory between the instruction-fetch path (IF) and the load/store path (D) of the RV32 core.
- Sits between the PC/fetch logic, the LSU and the memory macro, replacing separate instruction and data memories.
- Serialises accesses with a 3-state FSM and a latency counter, and returns read data or a write acknowledge to the requester that owns the access.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch path, the load/store path,
// the unified single-port memory and mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  // slave: the arbiter itself
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // master: requesters and memory surrounding the arbiter
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF and D accesses onto one fixed-latency single-port memory.
// Define ARB_ROUND_ROBIN_EN to alternate the winner on ties (default: D wins).
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int MEM_LAT = 2
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_reg;
  logic [3:0]    lat_cnt_reg;
  logic          owner_d_reg;
  logic          wr_reg;
  logic          mem_en_reg;
  logic          mem_we_reg;
  logic [AW-3:0] mem_addr_reg;
  logic [31:0]   mem_wdata_reg;
  logic [31:0]   if_rdata_reg;
  logic [31:0]   d_rdata_reg;

  logic idle;
  logic pick_d;
  logic if_gnt;
  logic d_gnt;
  logic done;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

  // Grants are also gated by reset so nothing is offered while rst is low.
  assign idle = rst & (state_reg == IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_d_reg;
  assign pick_d = bus.d_req & (~bus.if_req | ~last_owner_d_reg);
`else
  assign pick_d = bus.d_req;
`endif

  assign d_gnt  = idle & pick_d;
  assign if_gnt = idle & bus.if_req & ~pick_d;
  assign done   = (state_reg == WAIT) && (lat_cnt_reg == 4'd0);

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = done & ~owner_d_reg;
  assign bus.d_rvalid  = done & owner_d_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

  // Read data is forwarded in the rvalid cycle, then held by the owner's register.
  assign bus.if_rdata = (done & ~owner_d_reg) ? bus.mem_rdata : if_rdata_reg;
  assign bus.d_rdata  = (done & owner_d_reg & ~wr_reg) ? bus.mem_rdata : d_rdata_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      lat_cnt_reg   <= 4'd0;
      owner_d_reg   <= 1'b0;
      wr_reg        <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 32'd0;
      if_rdata_reg  <= 32'd0;
      d_rdata_reg   <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_d_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (if_gnt | d_gnt) begin
            owner_d_reg   <= d_gnt;
            wr_reg        <= d_gnt & bus.d_we;
            mem_en_reg    <= 1'b1;
            mem_we_reg    <= d_gnt & bus.d_we;
            mem_addr_reg  <= d_gnt ? bus.d_addr[AW-1:2] : bus.if_addr[AW-1:2];
            mem_wdata_reg <= d_gnt ? bus.d_wdata : 32'd0;
            state_reg     <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_d_reg <= d_gnt;
`endif
          end
        end
        ISSUE: begin
          mem_en_reg  <= 1'b0;
          mem_we_reg  <= 1'b0;
          lat_cnt_reg <= 4'(MEM_LAT - 1);
          state_reg   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt_reg == 4'd0) begin
            state_reg <= IDLE;
            if (!owner_d_reg)
              if_rdata_reg <= bus.mem_rdata;
            else if (!wr_reg)
              d_rdata_reg <= bus.mem_rdata;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
